// File: rtl/jt900h_idx_ctl.sv
// jt900h_idx_ctl -- indexed-addressing controller.
// Resolves one effective address per request: latches the request, collects
// up to two displacement bytes from the opcode stream, reads the register
// file for one CALC cycle (firing a post-increment or pre-decrement strobe
// where the mode asks for it), then reports ea/err with a one-cycle done.
// Optional feature macro: JT900H_IDXCTL_OFFSET_EN enables mode 5 (R+r16);
// without it mode 5 is reported as an illegal request.
module jt900h_idx_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [7:0]  base_sel,
  input  logic [7:0]  off_sel,
  input  logic [1:0]  size,
  input  logic [7:0]  op_byte,
  input  logic        op_valid,
  output logic        op_ack,
  output logic [7:0]  idx_rdreg_sel,
  output logic [7:0]  idx_rdreg_aux,
  output logic [1:0]  reg_step,
  output logic        reg_inc,
  output logic        reg_dec,
  input  logic [31:0] src_out,
  input  logic [31:0] dst_out,
  output logic        busy,
  output logic        done,
  output logic [23:0] ea,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DISP0 = 3'd1,
    DISP1 = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [2:0]  mode_q;
  logic [7:0]  base_q;
  logic [7:0]  off_q;
  logic [1:0]  size_q;
  logic [15:0] disp_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [23:0] ea_q;

  logic        in_calc;
  logic        in_disp;
  logic        err_cond;
  logic        use_off;
  logic [23:0] ea_d;
  logic        unused_bits;

  // Illegal requests: reserved modes, byte/word/long step with size code 3,
  // and mode 5 when the offset-register feature is not built in.
  function automatic logic is_err(input logic [2:0] md, input logic [1:0] sz);
    logic e;
    e = (md == 3'd6) || (md == 3'd7) ||
        ((sz == 2'd3) && ((md == 3'd3) || (md == 3'd4)));
`ifndef JT900H_IDXCTL_OFFSET_EN
    e = e || (md == 3'd5);
`endif
    return e;
  endfunction

  // Address arithmetic, modulo 2^24: base register plus a sign-extended
  // offset picked by the mode. Mode 3 takes the already-decremented port 1.
  function automatic logic [23:0] calc_ea(input logic [2:0]  md,
                                          input logic [23:0] src,
                                          input logic [23:0] dst,
                                          input logic [15:0] disp);
    logic signed [23:0] base_s;
    logic signed [23:0] off_s;
    base_s = (md == 3'd3) ? $signed(dst) : $signed(src);
    case (md)
      3'd1:    off_s = $signed({{16{disp[7]}}, disp[7:0]});
      3'd2:    off_s = $signed({{8{disp[15]}}, disp});
`ifdef JT900H_IDXCTL_OFFSET_EN
      3'd5:    off_s = $signed({{8{dst[15]}}, dst[15:0]});
`endif
      default: off_s = '0;
    endcase
    return base_s + off_s;
  endfunction

  assign in_calc  = (state_q == CALC);
  assign in_disp  = (state_q == DISP0) || (state_q == DISP1);
  assign err_cond = is_err(mode_q, size_q);
  assign ea_d     = err_cond ? 24'd0 : calc_ea(mode_q, src_out[23:0], dst_out[23:0], disp_q);

`ifdef JT900H_IDXCTL_OFFSET_EN
  assign use_off     = (mode_q == 3'd5);
  assign unused_bits = ^{src_out[31:24], dst_out[31:24]};
`else
  assign use_off     = 1'b0;
  assign unused_bits = ^{src_out[31:24], dst_out[31:24], off_q};
`endif

  // Handshake and register-file strobes are gated by cen and by reset so an
  // aborted request never consumes a byte or writes back a pointer.
  assign op_ack  = rst & cen & op_valid & in_disp;
  assign reg_dec = rst & cen & in_calc & (mode_q == 3'd3) & ~err_cond;
  assign reg_inc = rst & cen & in_calc & (mode_q == 3'd4) & ~err_cond;

  assign idx_rdreg_sel = in_calc ? base_q : 8'd0;
  assign idx_rdreg_aux = in_calc ? (use_off ? off_q : base_q) : 8'd0;
  assign reg_step      = size_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ea            = ea_q;
  assign err           = err_q;

  // Request FSM with its latched request fields and registered results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      base_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ea_q    <= '0;
    end else if (cen) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            base_q  <= base_sel;
            off_q   <= off_sel;
            size_q  <= size;
            disp_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ((mode == 3'd1) || (mode == 3'd2)) ? DISP0 : CALC;
          end
        end
        DISP0: begin
          if (op_valid) begin
            disp_q[7:0] <= op_byte;
            state_q     <= (mode_q == 3'd2) ? DISP1 : CALC;
          end
        end
        DISP1: begin
          if (op_valid) begin
            disp_q[15:8] <= op_byte;
            state_q      <= CALC;
          end
        end
        CALC: begin
          ea_q    <= ea_d;
          err_q   <= err_cond;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_idx_ctl.sv
// Testbench for jt900h_idx_ctl: directed addressing cases, randomized
// requests against an arithmetic reference model, hold and reset-abort cases.
module tb_jt900h_idx_ctl;

  logic        clk = 1'b0;
  logic        rst, cen, start, op_valid;
  logic [2:0]  mode;
  logic [7:0]  base_sel, off_sel, op_byte;
  logic [1:0]  size;
  logic [31:0] src_out, dst_out;
  logic        op_ack, reg_inc, reg_dec, busy, done, err;
  logic [7:0]  idx_rdreg_sel, idx_rdreg_aux;
  logic [1:0]  reg_step;
  logic [23:0] ea;

  int total = 0;
  int bad   = 0;

`ifdef JT900H_IDXCTL_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  jt900h_idx_ctl dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .mode(mode),
    .base_sel(base_sel), .off_sel(off_sel), .size(size),
    .op_byte(op_byte), .op_valid(op_valid), .op_ack(op_ack),
    .idx_rdreg_sel(idx_rdreg_sel), .idx_rdreg_aux(idx_rdreg_aux),
    .reg_step(reg_step), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .src_out(src_out), .dst_out(dst_out), .busy(busy), .done(done),
    .ea(ea), .err(err)
  );

  // ---------------- reference model ----------------
  function automatic bit m_err(input int md, input int sz);
    return (md >= 6) || (sz == 3 && (md == 3 || md == 4)) || (md == 5 && !OFF_EN);
  endfunction

  function automatic logic [23:0] m_ea(input int md, input int sz, input logic [31:0] s,
                                       input logic [31:0] d, input logic [15:0] dsp);
    int sb, off;
    if (m_err(md, sz)) return 24'd0;
    sb  = int'(s[23:0]);
    off = 0;
    case (md)
      1: off = (dsp[7:0] >= 8'd128) ? int'(dsp[7:0]) - 256 : int'(dsp[7:0]);
      2: off = (dsp >= 16'h8000) ? int'(dsp) - 65536 : int'(dsp);
      3: sb  = int'(d[23:0]);
      5: off = (d[15:0] >= 16'h8000) ? int'(d[15:0]) - 65536 : int'(d[15:0]);
      default: off = 0;
    endcase
    return 24'((sb + off) & 32'h00FF_FFFF);
  endfunction

  function automatic int m_lat(input int md, input int vd);
    return (md == 1) ? 3 + vd : (md == 2) ? 4 + vd : 2;
  endfunction

  function automatic int m_nack(input int md);
    return (md == 1) ? 1 : (md == 2) ? 2 : 0;
  endfunction

  // ---------------- request driver (observes, does not judge) ----------------
  task automatic txn(input logic [2:0] md, input logic [1:0] sz, input logic [7:0] b,
                     input logic [7:0] o, input logic [15:0] dsp, input logic [31:0] s,
                     input logic [31:0] d, input int vd, input bit rcen,
                     output logic [23:0] o_ea, output logic o_err, output int lat,
                     output int n_ack, output int n_inc, output int n_dec,
                     output logic [7:0] sel_c, output logic [7:0] aux_c,
                     output logic [1:0] step_c, output int viol, output bit tmo);
    int bidx;
    bit seen;
    logic [7:0] psel, paux;
    bidx = 0; seen = 0; psel = 0; paux = 0;
    o_ea = 'x; o_err = 'x; lat = -1; n_ack = 0; n_inc = 0; n_dec = 0;
    sel_c = 'x; aux_c = 'x; step_c = 'x; viol = 0; tmo = 1;
    @(negedge clk);
    start = 1; mode = md; base_sel = b; off_sel = o; size = sz; cen = 1;
    op_valid = 0; op_byte = 8'h00; src_out = s; dst_out = d;
    #1;
    if (busy || done || op_ack || reg_inc || reg_dec) viol++;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'($urandom); mode = 3'($urandom); base_sel = 8'($urandom);
      off_sel = 8'($urandom); size = 2'($urandom);
      cen = rcen ? ($urandom_range(0, 3) != 0) : 1'b1;
      op_valid = (c >= 1 + vd);
      op_byte = (bidx == 0) ? dsp[7:0] : (bidx == 1) ? dsp[15:8] : 8'($urandom);
      #1;
      if ((op_ack || reg_inc || reg_dec) && !cen) viol++;
      if (op_ack && !op_valid) viol++;
      if (op_ack) begin n_ack++; bidx++; end
      if (reg_inc) n_inc++;
      if (reg_dec) n_dec++;
      if (done && !seen) begin
        seen = 1; lat = c; sel_c = psel; aux_c = paux;
        o_ea = ea; o_err = err; step_c = reg_step;
        if (idx_rdreg_sel != 0 || idx_rdreg_aux != 0) viol++;
      end
      psel = idx_rdreg_sel; paux = idx_rdreg_aux;
      if (done && cen) begin tmo = 0; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk);
    rst = 0; cen = 1; start = 1; mode = 3'd4; size = 2'd1; base_sel = 8'hA5;
    off_sel = 8'h5A; op_valid = 1; op_byte = 8'h77;
    src_out = 32'h00ABCDEF; dst_out = 32'h00123456;
    @(negedge clk); #1;
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got busy/done/err=%b want 000", {busy, done, err}); end
    total++; if ({op_ack, reg_inc, reg_dec} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {op_ack, reg_inc, reg_dec}); end
    total++; if (ea !== 24'd0) begin bad++; $display("FAIL reset_ea: got %h want 000000", ea); end
    total++; if ({idx_rdreg_sel, idx_rdreg_aux, reg_step} !== 18'd0) begin bad++; $display("FAIL reset_sel: got %h/%h/%0d want 0", idx_rdreg_sel, idx_rdreg_aux, reg_step); end
    @(negedge clk);
    rst = 1; start = 0; op_valid = 0;
  endtask

  typedef struct {
    logic [2:0]  md;
    logic [1:0]  sz;
    logic [7:0]  b, o;
    logic [15:0] dsp;
    logic [31:0] s, d;
    int          vd;
  } vec_t;

  task automatic test_directed;
    vec_t v[9];
    logic [23:0] o_ea, e_ea;
    logic o_err;
    int lat, na, ni, nd, viol;
    logic [7:0] sc, ac;
    logic [1:0] st;
    bit tmo, e_err;
    v[0] = '{3'd0, 2'd0, 8'h12, 8'h34, 16'h0000, 32'h00123456, 32'h0BADF00D, 0};
    v[1] = '{3'd2, 2'd1, 8'h21, 8'h00, 16'hFFFE, 32'h00001000, 32'h00000000, 3};
    v[2] = '{3'd3, 2'd2, 8'h05, 8'h00, 16'h0000, 32'h00000000, 32'h0000FFFC, 0};
    v[3] = '{3'd4, 2'd3, 8'h06, 8'h00, 16'h0000, 32'h00ABCDEF, 32'h00000000, 0};
    v[4] = '{3'd4, 2'd1, 8'h07, 8'h00, 16'h0000, 32'h00400000, 32'h00000000, 0};
    v[5] = '{3'd1, 2'd0, 8'h08, 8'h00, 16'h0001, 32'h00FFFFFF, 32'h00000000, 0};
    v[6] = '{3'd5, 2'd1, 8'h09, 8'h0A, 16'h0000, 32'h00000100, 32'h0000FFF0, 0};
    v[7] = '{3'd6, 2'd0, 8'h0B, 8'h00, 16'h0000, 32'h00111111, 32'h00222222, 0};
    v[8] = '{3'd7, 2'd2, 8'h0C, 8'h00, 16'h0000, 32'h00333333, 32'h00444444, 0};
    for (int i = 0; i < 9; i++) begin
      txn(v[i].md, v[i].sz, v[i].b, v[i].o, v[i].dsp, v[i].s, v[i].d, v[i].vd, 1'b0,
          o_ea, o_err, lat, na, ni, nd, sc, ac, st, viol, tmo);
      e_ea  = m_ea(v[i].md, v[i].sz, v[i].s, v[i].d, v[i].dsp);
      e_err = m_err(v[i].md, v[i].sz);
      total++; if (tmo) begin bad++; $display("FAIL dir_timeout[%0d]: got no done want done", i); end
      total++; if (o_ea !== e_ea) begin bad++; $display("FAIL dir_ea[%0d]: got %h want %h", i, o_ea, e_ea); end
      total++; if (o_err !== e_err) begin bad++; $display("FAIL dir_err[%0d]: got %b want %b", i, o_err, e_err); end
      total++; if (lat != m_lat(v[i].md, v[i].vd)) begin bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, m_lat(v[i].md, v[i].vd)); end
      total++; if (na != m_nack(v[i].md)) begin bad++; $display("FAIL dir_op_ack[%0d]: got %0d want %0d", i, na, m_nack(v[i].md)); end
      total++; if (ni != ((v[i].md == 4 && !e_err) ? 1 : 0)) begin bad++; $display("FAIL dir_reg_inc[%0d]: got %0d pulses", i, ni); end
      total++; if (nd != ((v[i].md == 3 && !e_err) ? 1 : 0)) begin bad++; $display("FAIL dir_reg_dec[%0d]: got %0d pulses", i, nd); end
      total++; if (sc !== v[i].b) begin bad++; $display("FAIL dir_sel[%0d]: got %h want %h", i, sc, v[i].b); end
      total++; if (ac !== ((v[i].md == 5 && OFF_EN) ? v[i].o : v[i].b)) begin bad++; $display("FAIL dir_aux[%0d]: got %h", i, ac); end
      total++; if (st !== v[i].sz) begin bad++; $display("FAIL dir_step[%0d]: got %0d want %0d", i, st, v[i].sz); end
      total++; if (viol != 0) begin bad++; $display("FAIL dir_protocol[%0d]: got %0d violations want 0", i, viol); end
    end
  endtask

  task automatic test_hold;
    logic [23:0] o_ea, e_ea;
    logic o_err;
    int lat, na, ni, nd, viol;
    logic [7:0] sc, ac;
    logic [1:0] st;
    bit tmo;
    logic [31:0] s;
    s = $urandom;
    txn(3'd0, 2'd0, 8'h3C, 8'h00, 16'h0, s, 32'h0, 0, 1'b0, o_ea, o_err, lat, na, ni, nd, sc, ac, st, viol, tmo);
    e_ea = m_ea(0, 0, s, 32'h0, 16'h0);
    total++; if (o_ea !== e_ea) begin bad++; $display("FAIL hold_first_ea: got %h want %h", o_ea, e_ea); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = 0; cen = 1'($urandom); op_valid = 1'($urandom); mode = 3'($urandom);
      src_out = $urandom; dst_out = $urandom;
      #1;
      total++; if (ea !== e_ea) begin bad++; $display("FAIL hold_ea[%0d]: got %h want %h", c, ea, e_ea); end
      total++; if ({busy, done, op_ack, reg_inc, reg_dec} !== 5'b0) begin bad++; $display("FAIL hold_idle[%0d]: got %b want 00000", c, {busy, done, op_ack, reg_inc, reg_dec}); end
    end
  endtask

  task automatic test_random;
    logic [23:0] o_ea, e_ea;
    logic o_err;
    int lat, na, ni, nd, viol, vd;
    logic [7:0] sc, ac, b, o;
    logic [1:0] st, sz;
    logic [2:0] md;
    logic [15:0] dsp;
    logic [31:0] s, d;
    bit tmo, e_err, rcen;
    for (int i = 0; i < 40; i++) begin
      md = 3'($urandom); sz = 2'($urandom); b = 8'($urandom); o = 8'($urandom);
      dsp = 16'($urandom); s = $urandom; d = $urandom; vd = $urandom_range(0, 3);
      rcen = (i >= 20);
      txn(md, sz, b, o, dsp, s, d, vd, rcen, o_ea, o_err, lat, na, ni, nd, sc, ac, st, viol, tmo);
      e_ea  = m_ea(md, sz, s, d, dsp);
      e_err = m_err(md, sz);
      total++; if (tmo || viol != 0) begin bad++; $display("FAIL rnd_protocol[%0d]: got timeout=%0d violations=%0d want 0/0", i, tmo, viol); end
      total++; if (o_ea !== e_ea || o_err !== e_err) begin bad++; $display("FAIL rnd_result[%0d] mode=%0d: got ea=%h err=%b want ea=%h err=%b", i, md, o_ea, o_err, e_ea, e_err); end
      if (!rcen) begin
        total++; if (lat != m_lat(md, vd)) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, m_lat(md, vd)); end
      end
      total++; if (na != m_nack(md) || ni != ((md == 4 && !e_err) ? 1 : 0) || nd != ((md == 3 && !e_err) ? 1 : 0)) begin
        bad++; $display("FAIL rnd_strobes[%0d]: got ack=%0d inc=%0d dec=%0d", i, na, ni, nd);
      end
      total++; if (sc !== b || ac !== ((md == 5 && OFF_EN) ? o : b) || st !== sz) begin
        bad++; $display("FAIL rnd_selects[%0d]: got sel=%h aux=%h step=%0d", i, sc, ac, st);
      end
    end
  endtask

  task automatic test_reset_abort;
    int acks, dones, decs;
    bit bsy;
    // reset while waiting for the first displacement byte
    @(negedge clk);
    rst = 1; cen = 1; start = 1; mode = 3'd1; base_sel = 8'h44; size = 2'd0;
    op_valid = 0; src_out = 32'h00FFFFFF;
    @(negedge clk); start = 0;
    @(negedge clk); rst = 0; #1;
    total++; if (op_ack !== 1'b0) begin bad++; $display("FAIL abort_disp_ack: got %b want 0", op_ack); end
    @(negedge clk); rst = 1; op_valid = 1; op_byte = 8'h01;
    acks = 0; dones = 0; bsy = 0;
    repeat (6) begin #1; acks += int'(op_ack); dones += int'(done); bsy |= busy; @(negedge clk); end
    total++; if (acks != 0) begin bad++; $display("FAIL abort_disp_no_ack: got %0d want 0", acks); end
    total++; if (dones != 0 || bsy) begin bad++; $display("FAIL abort_disp_idle: got done=%0d busy=%b want 0/0", dones, bsy); end
    // reset during the register-file cycle of a pre-decrement
    start = 1; mode = 3'd3; size = 2'd2; base_sel = 8'h55; op_valid = 0;
    dst_out = 32'h0000FFFC;
    @(negedge clk); start = 0; rst = 0; #1;
    total++; if (reg_dec !== 1'b0) begin bad++; $display("FAIL abort_calc_dec: got %b want 0", reg_dec); end
    @(negedge clk); rst = 1;
    decs = 0; dones = 0; bsy = 0;
    repeat (5) begin #1; decs += int'(reg_dec); dones += int'(done); bsy |= busy; @(negedge clk); end
    total++; if (decs != 0 || dones != 0 || bsy) begin bad++; $display("FAIL abort_calc_idle: got dec=%0d done=%0d busy=%b want 0/0/0", decs, dones, bsy); end
    total++; if (ea !== 24'd0) begin bad++; $display("FAIL abort_calc_ea: got %h want 000000", ea); end
  endtask

  initial begin
    rst = 0; cen = 1; start = 0; mode = 0; base_sel = 0; off_sel = 0; size = 0;
    op_byte = 0; op_valid = 0; src_out = 0; dst_out = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt900h_idx_ctl.md
JT900H_IDX_CTL -- requirements
Module: jt900h_idx_ctl

Interface
REQ-001 clk  input  1  clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-003 cen  input  1  clock enable; the FSM, latches and handshakes advance only when cen=1.
REQ-004 start  input  1  request pulse; sampled in IDLE only.
REQ-005 mode  input  3  0 (R), 1 (R+d8), 2 (R+d16), 3 (-R), 4 (R+), 5 (R+r16), 6/7 reserved.
REQ-006 base_sel  input  8  register-file code of the base pointer.
REQ-007 off_sel  input  8  register-file code of the offset register (mode 5).
REQ-008 size  input  2  step size: 0 byte, 1 word, 2 long, 3 illegal.
REQ-009 op_byte  input  8  displacement byte from the opcode stream.
REQ-010 op_valid  input  1  op_byte valid.
REQ-011 op_ack  output  1  op_byte consumed this cycle.
REQ-012 idx_rdreg_sel  output  8  register-file read port 0 select.
REQ-013 idx_rdreg_aux  output  8  register-file read port 1 select.
REQ-014 reg_step  output  2  register-file step code (equals latched size).
REQ-015 reg_inc  output  1  post-increment write strobe.
REQ-016 reg_dec  output  1  pre-decrement write strobe.
REQ-017 src_out  input  32  register-file port 0 data.
REQ-018 dst_out  input  32  register-file port 1 data (already decremented while reg_dec=1).
REQ-019 busy  output  1  request in progress.
REQ-020 done  output  1  one-cen-cycle completion pulse.
REQ-021 ea  output  24  effective address; valid while done=1, held until the next request completes.
REQ-022 err  output  1  illegal request flag; valid while done=1.

Function
REQ-023 The FSM SHALL have exactly the states IDLE, DISP0, DISP1, CALC and DONE.
REQ-024 In IDLE with start=1 and cen=1, the block SHALL latch mode, base_sel, off_sel and size and set busy=1. The next state SHALL be DISP0 for modes 1/2 and CALC otherwise.
REQ-025 DISP0/DISP1 SHALL wait while op_valid=0. With op_valid=1 and cen=1 they SHALL assert op_ack for that cycle and latch disp[7:0]/disp[15:8].
REQ-026 DISP0 SHALL go to CALC for mode 1 and to DISP1 for mode 2. DISP1 SHALL go to CALC.
REQ-027 In CALC, idx_rdreg_sel SHALL equal base_sel. idx_rdreg_aux SHALL equal off_sel for mode 5 and base_sel otherwise.
REQ-028 ea SHALL be registered in CALC, using modulo 2^24 arithmetic:
  - mode 0: src_out[23:0]
  - mode 1: src_out + sext(disp[7:0])
  - mode 2: src_out + sext(disp[15:0])
  - mode 3: dst_out[23:0]
  - mode 4: src_out[23:0]
  - mode 5: src_out + sext(dst_out[15:0])
REQ-029 reg_dec SHALL be (state==CALC)&(mode==3)&cen&~err_cond, and reg_inc SHALL be (state==CALC)&(mode==4)&cen&~err_cond, so each is high for exactly one clk.
REQ-030 err_cond SHALL be: mode 6/7, or size=3 with mode 3/4. Under err_cond, ea SHALL be 0, no strobe SHALL fire, and err=1 in DONE.
REQ-031 CALC SHALL go to DONE. DONE SHALL assert done for one cen cycle, then go to IDLE with busy=0. start SHALL be ignored outside IDLE.
REQ-032 Latency with cen=1 and op_valid=1 throughout SHALL be: done 2 cycles after start is sampled for modes 0/3/4/5, 3 cycles for mode 1, 4 cycles for mode 2.
REQ-033 With cen=0, all outputs and state SHALL hold, and op_ack/reg_inc/reg_dec SHALL be 0.
REQ-034 Outside CALC, the selects SHALL be 0 and reg_inc/reg_dec SHALL be 0.

Reset
REQ-035 With rst=0 at a clk edge, the FSM SHALL enter IDLE. busy, done, err, op_ack, reg_inc, reg_dec, ea, disp, the selects and reg_step SHALL be 0.
REQ-036 Reset during any state, including CALC, SHALL abort the request with no register write, no done pulse, and partial displacement discarded.

Configuration
REQ-037 Macro JT900H_IDXCTL_OFFSET_EN: when defined, mode 5 SHALL behave per REQ-028.
REQ-038 When JT900H_IDXCTL_OFFSET_EN is undefined, mode 5 SHALL be treated as err_cond, and idx_rdreg_aux SHALL equal base_sel.

Verification
REQ-039 Mode 0, src_out=0x00123456 -> done two cycles after start, ea=0x123456, err=0, no strobes.
REQ-040 Mode 2, src_out=0x00001000, op_valid delayed 3 cycles, bytes 0xFE,0xFF -> two op_ack pulses, ea=0x000FFE.
REQ-041 Mode 3, size=2, dst_out (decremented)=0x0000FFFC -> single-clk reg_dec, reg_step=2, ea=0x00FFFC.
REQ-042 Mode 4, size=3 -> err=1, ea=0, reg_inc never asserted; with size=1 -> one reg_inc pulse, reg_step=1.
REQ-043 Mode 1 with src_out=0x00FFFFFF, disp=0x01 -> ea=0x000000 (wrap); rst=0 asserted in DISP0 -> IDLE, no done, no op_ack afterwards.
REQ-044 Mode 5, src_out=0x100, dst_out=0x0000FFF0 -> ea=0x0000F0 with JT900H_IDXCTL_OFFSET_EN defined; err=1, ea=0 without it.
